// File: rtl/arch_defs_pkg.sv
// rtl/arch_defs_pkg.sv - shared architecture widths, flag and output-entry types
package arch_defs_pkg;

    localparam int DATA_WIDTH     = 8;
    localparam int OUT_FIFO_DEPTH = 4;

    // CPU condition flags, shared with the flags register
    typedef struct packed {
        logic negative;
        logic carry;
        logic zero;
    } flags_t;

    // One buffered OUT result: flags sampled alongside the payload
    typedef struct packed {
        flags_t                flags;
        logic [DATA_WIDTH-1:0] data;
    } out_entry_t;

    function automatic out_entry_t make_entry(input flags_t f, input logic [DATA_WIDTH-1:0] d);
        make_entry.flags = f;
        make_entry.data  = d;
    endfunction

endpackage

// File: rtl/out_fifo_mem.sv
// rtl/out_fifo_mem.sv - register array, synchronous write, asynchronous read
module out_fifo_mem #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Array is cleared on reset so the head output is never X
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/out_port_fifo.sv
// rtl/out_port_fifo.sv - FWFT output-port FIFO with sticky overrun flag
module out_port_fifo #(
    parameter int DATA_WIDTH = arch_defs_pkg::DATA_WIDTH,
    parameter int DEPTH      = arch_defs_pkg::OUT_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_i,
    input  logic [DATA_WIDTH-1:0]      data_i,
    input  logic [2:0]                 flags_i,
    input  logic                       ready_i,
    output logic                       valid_o,
    output logic [DATA_WIDTH-1:0]      data_o,
    output logic [2:0]                 flags_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       overflow_o,
    input  logic                       clear_ovf_i
);

    import arch_defs_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = DATA_WIDTH + 3;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          ovf_q;
    logic          push;
    logic          pop;
    logic          overrun;
    logic [EW-1:0] head;
    flags_t        head_flags;

    // Status comes purely from the occupancy register
    assign valid_o    = (count_q != '0);
    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CW'(DEPTH));
    assign count_o    = count_q;
    assign overflow_o = ovf_q;

    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign pop     = valid_o && ready_i;
    assign push    = load_i && (!full_o || pop);
    assign overrun = load_i && full_o && !pop;

    out_fifo_mem #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({flags_i, data_i}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    assign head_flags = flags_t'(head[EW-1 -: 3]);
    assign flags_o    = head_flags;
    assign data_o     = head[DATA_WIDTH-1:0];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // Occupancy moves only when exactly one of push/pop happens
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky overrun; a new overrun beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (overrun) begin
            ovf_q <= 1'b1;
        end else if (clear_ovf_i) begin
            ovf_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_out_port_fifo.sv
// tb/tb_out_port_fifo.sv - self-checking bench for out_port_fifo
module tb_out_port_fifo;

    localparam int DW = 8;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_i;
    logic [DW-1:0] data_i;
    logic [2:0]    flags_i;
    logic          ready_i;
    logic          valid_o;
    logic [DW-1:0] data_o;
    logic [2:0]    flags_o;
    logic [2:0]    count_o;
    logic          full_o;
    logic          empty_o;
    logic          overflow_o;
    logic          clear_ovf_i;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW+2:0] mq[$];
    logic          m_ovf = 1'b0;
    logic          started = 1'b0;

    out_port_fifo #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_i      (load_i),
        .data_i      (data_i),
        .flags_i     (flags_i),
        .ready_i     (ready_i),
        .valid_o     (valid_o),
        .data_o      (data_o),
        .flags_o     (flags_o),
        .count_o     (count_o),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .overflow_o  (overflow_o),
        .clear_ovf_i (clear_ovf_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Queue model: a bounded list with pop-before-push ordering
    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_ovf   <= 1'b0;
            started <= 1'b1;
        end else begin
            if (load_i && mq.size() == DP && !(ready_i && mq.size() > 0))
                m_ovf <= 1'b1;
            else if (clear_ovf_i)
                m_ovf <= 1'b0;
            if (load_i && (mq.size() < DP || ready_i)) begin
                if (ready_i && mq.size() > 0) void'(mq.pop_front());
                mq.push_back({flags_i, data_i});
            end else if (ready_i && mq.size() > 0) begin
                void'(mq.pop_front());
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (started) begin
            chk("m_count", count_o, mq.size());
            chk("m_valid", valid_o, mq.size() != 0);
            chk("m_empty", empty_o, mq.size() == 0);
            chk("m_full", full_o, mq.size() == DP);
            chk("m_ovf", overflow_o, m_ovf);
            if (mq.size() != 0) chk("m_head", {flags_o, data_o}, mq[0]);
        end
    end

    task automatic step(input logic ld, input logic [DW-1:0] d, input logic [2:0] f,
                        input logic rdy, input logic clr);
        load_i = ld; data_i = d; flags_i = f; ready_i = rdy; clear_ovf_i = clr;
        @(posedge clk);
        #1;
        load_i = 1'b0; ready_i = 1'b0; clear_ovf_i = 1'b0;
    endtask

    initial begin
        reset = 1'b1; load_i = 1'b0; data_i = '0; flags_i = '0; ready_i = 1'b0; clear_ovf_i = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_count", count_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_empty", empty_o, 1);
        chk("rst_full", full_o, 0);
        chk("rst_ovf", overflow_o, 0);
        chk("rst_data", data_o, 8'h00);
        chk("rst_flags", flags_o, 3'b000);

        // Single push with N=1 becomes visible next cycle
        step(1, 8'hF0, 3'b100, 0, 0);
        chk("t1_valid", valid_o, 1);
        chk("t1_data", data_o, 8'hF0);
        chk("t1_flags", flags_o, 3'b100);
        chk("t1_count", count_o, 1);
        step(0, 0, 0, 1, 0);
        chk("t1_empty", empty_o, 1);

        // Back-to-back pushes pop in order
        step(1, 8'h00, 3'b001, 0, 0);
        step(1, 8'h0F, 3'b000, 0, 0);
        chk("t2_head0", {flags_o, data_o}, {3'b001, 8'h00});
        step(0, 0, 0, 1, 0);
        chk("t2_head1", {flags_o, data_o}, {3'b000, 8'h0F});
        step(0, 0, 0, 1, 0);
        chk("t2_empty", empty_o, 1);

        // Five pushes into four slots: overrun latched, fifth dropped
        for (int i = 1; i <= 5; i++) step(1, DW'(i), 3'b000, 0, 0);
        chk("t3_full", full_o, 1);
        chk("t3_count", count_o, 4);
        chk("t3_ovf", overflow_o, 1);
        for (int i = 1; i <= 4; i++) begin
            chk("t3_drain", data_o, i);
            step(0, 0, 0, 1, 0);
        end
        chk("t3_empty", empty_o, 1);
        step(0, 0, 0, 0, 1);
        chk("t3_clr", overflow_o, 0);

        // Push while full with a simultaneous pop, repeated to wrap pointers
        for (int i = 0; i < 4; i++) step(1, 8'h11 + DW'(i), 3'b010, 0, 0);
        step(1, 8'h15, 3'b011, 1, 0);
        chk("t4_count", count_o, 4);
        chk("t4_ovf", overflow_o, 0);
        chk("t4_head", data_o, 8'h12);
        for (int i = 0; i < 3; i++) step(1, 8'h16 + DW'(i), 3'b000, 1, 0);
        chk("t4_wrap_head", {flags_o, data_o}, {3'b011, 8'h15});
        chk("t4_wrap_count", count_o, 4);

        // Overrun and clear in the same cycle: set wins
        step(1, 8'h99, 3'b111, 0, 1);
        chk("t5_set_wins", overflow_o, 1);
        chk("t5_count", count_o, 4);
        step(0, 0, 0, 0, 1);
        chk("t5_clear", overflow_o, 0);

        // Reset with three entries queued overrides a concurrent load
        step(0, 0, 0, 1, 0);
        chk("t6_pre", count_o, 3);
        reset = 1'b1;
        step(1, 8'hAA, 3'b101, 1, 0);
        reset = 1'b0;
        chk("t6_count", count_o, 0);
        chk("t6_valid", valid_o, 0);
        chk("t6_data", data_o, 8'h00);

        // Mixed traffic checked by the model every cycle
        for (int i = 0; i < 60; i++)
            step(($urandom_range(0, 2) != 0), DW'($urandom), 3'($urandom),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 7) == 0));
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0);
        chk("end_empty", empty_o, 1);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/out_port_fifo.md
# out_port_fifo

Buffered output port on the downstream side of the `computer` output register. Each cycle the CPU asserts its output-load strobe, the block captures `out_val` together with the current Z/C/N flags into a small first-word-fall-through FIFO. A consumer such as a display driver or UART drains the FIFO over a valid/ready handshake. A CPU program can therefore emit bursts of OUT results without stalling on a slow sink; overruns are detected and latched.

## Interface
Parameters:
- `DATA_WIDTH`, default `arch_defs_pkg::DATA_WIDTH` (8): payload width.
- `DEPTH`, default 4: number of entries. Must be a power of two and ≥ 2.

Ports:
- `clk`, in, 1: single system clock; all state updates on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `load_i`, in, 1: push strobe from the CPU output-register load.
- `data_i`, in, DATA_WIDTH: value to push (the CPU `out_val`).
- `flags_i`, in, 3: `{negative, carry, zero}` sampled with `data_i`.
- `ready_i`, in, 1: sink accepts the head entry this cycle.
- `valid_o`, out, 1: head entry present.
- `data_o`, out, DATA_WIDTH: head payload.
- `flags_o`, out, 3: head flags, same order as `flags_i`.
- `count_o`, out, $clog2(DEPTH+1): occupancy, 0..DEPTH.
- `full_o`, out, 1: `count_o == DEPTH`.
- `empty_o`, out, 1: `count_o == 0`.
- `overflow_o`, out, 1: sticky overrun indicator.
- `clear_ovf_i`, in, 1: clears `overflow_o`.

## Operation
- Storage: DEPTH entries of DATA_WIDTH+3 bits, with read and write pointers of $clog2(DEPTH) bits. Pointers wrap naturally from DEPTH-1 to 0.
- push = `load_i && (!full_o || pop)`; pop = `valid_o && ready_i`.
- Push writes `{flags_i, data_i}` at the write pointer and increments it. Pop increments the read pointer.
- Occupancy: `count_o` +1 on push only, -1 on pop only, unchanged on both or neither.
- Full with simultaneous pop: the push succeeds and the count stays at DEPTH.
- Empty: `valid_o` = 0, so no pop is possible. A push while empty is not bypassed; it becomes visible the next cycle.
- Overrun: `load_i` while full and no pop drops the data, leaves the FIFO unchanged, and sets `overflow_o`.
- `overflow_o` stays set until `clear_ovf_i` or `reset`. If a set and `clear_ovf_i` occur in the same cycle, the set wins.
- `data_o`/`flags_o` show the entry at the read pointer (FWFT). Their value while `valid_o`=0 is don't-care but must not be X after reset, so the storage array is also reset to 0.
- `ready_i` while empty has no effect.

## Timing
- Reset values (first edge with `reset`=1): pointers 0, `count_o` 0, `empty_o` 1, `full_o` 0, `valid_o` 0, `overflow_o` 0, `data_o` 0, `flags_o` 0.
- `reset` overrides every other input in that cycle. A reset mid-burst discards all entries.
- Push latency: data pushed at edge N gives `valid_o`=1 and correct `data_o`/`flags_o` after edge N, i.e. during cycle N+1.
- Pop: head advances at the edge where `valid_o && ready_i`; the next entry, or `valid_o`=0, is visible right after.
- `valid_o`, `full_o`, `empty_o`, `count_o` and `overflow_o` are driven from registers or pointer compares only. There is no combinational path from `ready_i` or `load_i` to any output.
- Throughput: one push and one pop per cycle, sustained.

## Structure
- `arch_defs_pkg` gains:
  - `OUT_FIFO_DEPTH = 4`;
  - `flags_t`, a packed struct `{logic negative; logic carry; logic zero;}`, shared with the CPU flags register;
  - `out_entry_t = {flags_t, logic [DATA_WIDTH-1:0]}`.
- One sub-module is natural: `out_fifo_mem`, a DEPTH × out_entry_t register array with synchronous write and asynchronous read. Pointer, count and overflow logic stay in `out_port_fifo`.
- `computer` instantiates the block with `load_i` tied to the output-register load control and `flags_i` tied to the latched flags.

## Test plan
- Reset, then push `8'hF0` with flags Z=0 C=0 N=1, `ready_i`=0 → next cycle `valid_o`=1, `data_o`=F0, `flags_o`=3'b100, `count_o`=1.
- Push `8'h00` (Z=1) then `8'h0F` (flags 0) on back-to-back cycles, then set `ready_i`=1 → pops in order: 00/3'b001, then 0F/3'b000; `empty_o`=1 after the second pop.
- Push 5 values `01`..`05` with `ready_i`=0 → `full_o`=1, `count_o`=4, `overflow_o`=1; draining yields `01`..`04` only.
- Fill to 4, then `load_i` together with `ready_i` in one cycle → `count_o` stays 4, `overflow_o` stays 0, new value emerges last; run 3+ cycles of wrap to confirm pointer wrap.
- `overflow_o`=1, drive `clear_ovf_i` and an overrun in the same cycle → `overflow_o` remains 1; clear alone → 0.
- Assert `reset` with 3 entries queued → next cycle `count_o`=0, `valid_o`=0, `data_o`=00.
